// File: rtl/i2s_clkgen.sv
// i2s_clkgen: I2S/TDM clock generator.
//   Derives BCLK and LRCLK/frame-sync from mclk and provides per-period strobes
//   plus the slot/bit position for the serializer and deserializer. Starts and
//   stops only on frame boundaries.
// Ports:
//   mclk        master clock, all logic on its rising edge
//   mrst        synchronous active-high reset (highest priority)
//   en          run request; sampled in IDLE to start, at frame end to stop
//   fmt         0 = 50%-duty LRCLK, 1 = one-BCLK frame-sync pulse
//   bclk        bit clock (registered)
//   lrclk       frame clock / frame sync (registered)
//   bclk_fall   one-cycle strobe at the start of each BCLK period
//   bclk_rise   one-cycle strobe in the first cycle BCLK reads 1
//   frame_start one-cycle strobe at the first BCLK period of a frame
//   slot        current slot index
//   bit_idx     current bit index within the slot (0 = MSB period)
//   active      high while frames are being generated
module i2s_clkgen #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2,
  localparam int SW = ($clog2(NUM_SLOTS) > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int BW = $clog2(SLOT_BITS),
  localparam int DW = $clog2(BCLK_DIV)
) (
  input  logic          mclk,
  input  logic          mrst,
  input  logic          en,
  input  logic          fmt,
  output logic          bclk,
  output logic          lrclk,
  output logic          bclk_fall,
  output logic          bclk_rise,
  output logic          frame_start,
  output logic [SW-1:0] slot,
  output logic [BW-1:0] bit_idx,
  output logic          active
);

  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [SW-1:0] SLOT_HALF = SW'(NUM_SLOTS / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] slot_cnt;
  logic          fmt_q;
  logic          div_end, bit_end, slot_end, frame_end;

  assign div_end   = (div_cnt == DIV_LAST);
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = div_end && bit_end && slot_end;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (frame_end && !en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters hold the position the output register will present one cycle
  // later. They are already 0 whenever a stop happens because the frame-end
  // wrap lands on 0, so IDLE never needs to clear them.
  always_ff @(posedge mclk) begin
    if (mrst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      fmt_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (en) fmt_q <= fmt;
      end else begin
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        if (div_end) bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (div_end && bit_end) slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
        // Format for the next frame is captured as the current one ends.
        if (frame_end) fmt_q <= fmt;
      end
    end
  end

  // Registered output decode of the counter position.
  always_ff @(posedge mclk) begin
    if (mrst || state == IDLE) begin
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      bclk_fall   <= 1'b0;
      bclk_rise   <= 1'b0;
      frame_start <= 1'b0;
      slot        <= '0;
      bit_idx     <= '0;
      active      <= 1'b0;
    end else begin
      bclk        <= (div_cnt >= DIV_HALF);
      bclk_fall   <= (div_cnt == '0);
      bclk_rise   <= (div_cnt == DIV_HALF);
      frame_start <= (div_cnt == '0) && (bit_cnt == '0) && (slot_cnt == '0);
      slot        <= slot_cnt;
      bit_idx     <= bit_cnt;
      active      <= 1'b1;
      lrclk       <= fmt_q ? ((slot_cnt == '0) && (bit_cnt == '0))
                           : (slot_cnt >= SLOT_HALF);
    end
  end

endmodule
